ghost_mode_scheduler: RTL and testbench
=======================================

GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 16'd50000: clock cycles per ghost move tick; legal range 2..65535.
REQ-002 Parameter SCATTER_TICKS, default 8'd28: ticks per scatter phase; legal range 1..255.
REQ-003 Parameter CHASE_TICKS, default 8'd80: ticks per finite chase phase; legal range 1..255.
REQ-004 Parameter FRIGHT_TICKS, default 8'd24: ticks of frightened mode per power pellet; legal range 1..255.
REQ-005 clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  game running; low freezes the prescaler and all tick-driven timers.
REQ-008 pellet  in  1  one-cycle pulse: Pac-Man ate a power pellet.
REQ-009 caught  in  1  one-cycle pulse: Pac-Man collided with this ghost.
REQ-010 at_home  in  1  level: ghost location equals the ghost-house target.
REQ-011 mode  out  4  one-hot ghost mode: Chase 4'b1000, Scatter 4'b0100, Frightened 4'b0010, Eaten 4'b0001.
REQ-012 rotate  out  1  reverse-direction request to the ghost AI.
REQ-013 update  out  1  one-cycle move strobe to the ghost AI.
REQ-014 phase  out  3  current scatter/chase phase index, 0..7.

Function
REQ-015 The prescaler shall count 0..TICK_DIV-1 while enable=1, hold while enable=0, and wrap to 0 after TICK_DIV-1.
REQ-016 A tick shall be the cycle with prescaler==TICK_DIV-1 and enable=1; update shall be registered high exactly for the cycle after each tick.
REQ-017 Phase schedule: even phases (0,2,4,6) are Scatter for SCATTER_TICKS; phases 1,3,5 are Chase for CHASE_TICKS; phase 7 is Chase indefinitely (no further transitions).
REQ-018 The 8-bit phase timer shall decrement once per tick only while mode is Scatter or Chase; it is frozen in Frightened and Eaten.
REQ-019 When the phase timer decrements to 0 on a tick, phase shall increment, the timer shall reload for the new phase, and mode shall toggle Scatter/Chase; these changes and rotate=1 shall appear on the same edge that raises update.
REQ-020 pellet in Scatter or Chase: mode shall become Frightened on the next edge, the fright timer shall load FRIGHT_TICKS, and rotate shall be set.
REQ-021 pellet in Frightened: reload the fright timer to FRIGHT_TICKS; rotate unchanged.
REQ-022 pellet in Eaten: ignored.
REQ-023 The fright timer shall decrement once per tick in Frightened; on reaching 0, mode shall return to the phase mode (even phase Scatter, odd phase Chase) with no rotate.
REQ-024 caught in Frightened: mode shall become Eaten on the next edge and the fright timer shall clear; rotate is not set.
REQ-025 caught in Scatter, Chase or Eaten: ignored (Pac-Man death is handled elsewhere).
REQ-026 at_home=1 while in Eaten: mode shall return to the phase mode on the next edge with no rotate; at_home shall be ignored in all other modes.
REQ-027 Priority on the same edge: caught over pellet over fright expiry; a pellet on the fright-expiry tick leaves mode Frightened with a reload.
REQ-028 rotate, once set, shall stay high until the edge that ends the next update pulse, then clear, unless set again on that same edge.
REQ-029 pellet, caught and at_home shall be processed regardless of enable.
REQ-030 mode shall always be exactly one-hot; phase shall saturate at 7.

Reset
REQ-031 resetn low shall immediately force mode=4'b0100, phase=0, phase timer=SCATTER_TICKS, fright timer=0, prescaler=0, update=0, rotate=0.
REQ-032 Reset asserted mid-Frightened or mid-Eaten shall discard all pending state; operation restarts at phase 0 on the first tick after release.

Verification (TICK_DIV=4, SCATTER_TICKS=3, CHASE_TICKS=5, FRIGHT_TICKS=4)
REQ-033 Release reset with enable=1 -> update pulses every 4 cycles; after the 3rd tick, mode=1000, phase=1, rotate=1 with that update, rotate=0 after the following update.
REQ-034 Run 7 full phases -> phase=7, mode=1000, no further mode change over 1000 ticks.
REQ-035 pellet in Chase at phase 1, 2 ticks elapsed -> mode=0010, rotate=1; after 4 ticks, mode=1000 with 3 chase ticks remaining, rotate=0.
REQ-036 pellet and caught in the same cycle while Frightened -> mode=0001; then at_home=1 -> phase mode restored, rotate stays 0.
REQ-037 enable=0 for 20 cycles in Scatter -> no update, phase timer unchanged; pellet during that window still yields mode=0010.
REQ-038 resetn low while Eaten, phase=3 -> outputs equal REQ-031 values within the same cycle, asynchronously.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour scheduler: scatter/chase phase sequencing, frightened and eaten
// overrides, a move-tick prescaler and the reverse-direction request for the ghost AI.
module ghost_mode_scheduler #(
   parameter logic [15:0] TICK_DIV      = 16'd50000,
   parameter logic [7:0]  SCATTER_TICKS = 8'd28,
   parameter logic [7:0]  CHASE_TICKS   = 8'd80,
   parameter logic [7:0]  FRIGHT_TICKS  = 8'd24
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       pellet,
   input  logic       caught,
   input  logic       at_home,
   output logic [3:0] mode,
   output logic       rotate,
   output logic       update,
   output logic [2:0] phase
);

   typedef enum logic [3:0] {
      CHASE   = 4'b1000,
      SCATTER = 4'b0100,
      FRIGHT  = 4'b0010,
      EATEN   = 4'b0001
   } mode_t;

   mode_t       r_mode;
   mode_t       w_modeNext;
   mode_t       w_phaseMode;
   logic [2:0]  r_phase;
   logic [2:0]  w_phaseNext;
   logic [7:0]  r_phaseTimer;
   logic [7:0]  w_phaseTimerNext;
   logic [7:0]  r_frightTimer;
   logic [7:0]  w_frightTimerNext;
   logic [15:0] r_presc;
   logic        r_update;
   logic        r_rotate;
   logic        r_armed;
   logic        w_setRotate;
   logic        w_rotateNext;
   logic        w_tick;

   assign w_tick      = enable && (r_presc == TICK_DIV - 16'd1);
   assign w_phaseMode = r_phase[0] ? CHASE : SCATTER;

   // Mode transitions; caught outranks pellet, which outranks fright expiry.
   always_comb begin
      w_modeNext        = r_mode;
      w_phaseNext       = r_phase;
      w_phaseTimerNext  = r_phaseTimer;
      w_frightTimerNext = r_frightTimer;
      w_setRotate       = 1'b0;
      case (r_mode)
         SCATTER, CHASE: begin
            if (w_tick && r_phase != 3'd7) begin
               if (r_phaseTimer <= 8'd1) begin
                  w_phaseNext      = r_phase + 3'd1;
                  // The new phase has the opposite parity of the current one.
                  w_phaseTimerNext = r_phase[0] ? SCATTER_TICKS : CHASE_TICKS;
                  w_modeNext       = (r_mode == SCATTER) ? CHASE : SCATTER;
                  w_setRotate      = 1'b1;
               end else begin
                  w_phaseTimerNext = r_phaseTimer - 8'd1;
               end
            end
            if (pellet) begin
               w_modeNext        = FRIGHT;
               w_frightTimerNext = FRIGHT_TICKS;
               w_setRotate       = 1'b1;
            end
         end
         FRIGHT: begin
            if (caught) begin
               w_modeNext        = EATEN;
               w_frightTimerNext = 8'd0;
            end else if (pellet) begin
               w_frightTimerNext = FRIGHT_TICKS;
            end else if (w_tick) begin
               if (r_frightTimer <= 8'd1) begin
                  w_modeNext        = w_phaseMode;
                  w_frightTimerNext = 8'd0;
               end else begin
                  w_frightTimerNext = r_frightTimer - 8'd1;
               end
            end
         end
         EATEN: begin
            if (at_home) begin
               w_modeNext = w_phaseMode;
            end
         end
         default: w_modeNext = SCATTER;
      endcase
   end

   // A rotate raised alongside an update survives that pulse and drops with the next one.
   assign w_rotateNext = w_setRotate ? 1'b1 : ((r_update && r_armed) ? 1'b0 : r_rotate);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_mode        <= SCATTER;
         r_phase       <= 3'd0;
         r_phaseTimer  <= SCATTER_TICKS;
         r_frightTimer <= 8'd0;
         r_presc       <= 16'd0;
         r_update      <= 1'b0;
         r_rotate      <= 1'b0;
         r_armed       <= 1'b0;
      end else begin
         r_mode        <= w_modeNext;
         r_phase       <= w_phaseNext;
         r_phaseTimer  <= w_phaseTimerNext;
         r_frightTimer <= w_frightTimerNext;
         r_update      <= w_tick;
         r_rotate      <= w_rotateNext;
         if (w_tick) begin
            r_armed <= r_rotate;
            r_presc <= 16'd0;
         end else if (enable) begin
            r_presc <= r_presc + 16'd1;
         end
      end
   end

   assign mode   = r_mode;
   assign phase  = r_phase;
   assign update = r_update;
   assign rotate = r_rotate;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed testbench for ghost_mode_scheduler with a small tick divider and short phases.
module tb_ghost_mode_scheduler;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       pellet = 1'b0;
   logic       caught = 1'b0;
   logic       at_home = 1'b0;
   logic [3:0] mode;
   logic       rotate;
   logic       update;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   ghost_mode_scheduler #(
      .TICK_DIV(16'd4),
      .SCATTER_TICKS(8'd3),
      .CHASE_TICKS(8'd5),
      .FRIGHT_TICKS(8'd4)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .enable(enable),
      .pellet(pellet),
      .caught(caught),
      .at_home(at_home),
      .mode(mode),
      .rotate(rotate),
      .update(update),
      .phase(phase)
   );

   always #5 clock = ~clock;

   // Advance to the cycle just after the next tick edge, bounded.
   task automatic nextUpdate(output int cycles);
      bit found;
      found  = 1'b0;
      cycles = -1;
      for (int i = 1; i <= 64 && !found; i++) begin
         @(posedge clock);
         #1;
         if (update === 1'b1) begin
            found  = 1'b1;
            cycles = i;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL update_timeout: got no update in 64 cycles, required one");
      end
   endtask

   task automatic pulse(input logic p, input logic c, input logic h);
      pellet  = p;
      caught  = c;
      at_home = h;
      @(posedge clock);
      #1;
      pellet  = 1'b0;
      caught  = 1'b0;
      at_home = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      enable = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (mode !== 4'b0100) begin errors++; $display("[TB] FAIL reset_mode: got %b required %b", mode, 4'b0100); end
      checks++;
      if (phase !== 3'd0) begin errors++; $display("[TB] FAIL reset_phase: got %0d required 0", phase); end
      checks++;
      if (update !== 1'b0 || rotate !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got update=%b rotate=%b required 0/0", update, rotate); end
      enable = 1'b1;
      resetn = 1'b1;
   endtask

   task automatic test_schedule;
      int n;
      nextUpdate(n);
      checks++;
      if (n !== 4) begin errors++; $display("[TB] FAIL first_tick_latency: got %0d required 4", n); end
      checks++;
      if (mode !== 4'b0100 || phase !== 3'd0) begin errors++; $display("[TB] FAIL tick1_state: got mode=%b phase=%0d required 0100/0", mode, phase); end
      nextUpdate(n);
      checks++;
      if (n !== 4) begin errors++; $display("[TB] FAIL tick_period: got %0d required 4", n); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd1 || rotate !== 1'b1) begin errors++; $display("[TB] FAIL phase1_entry: got mode=%b phase=%0d rotate=%b required 1000/1/1", mode, phase, rotate); end
      @(posedge clock);
      #1;
      checks++;
      if (update !== 1'b0 || rotate !== 1'b1) begin errors++; $display("[TB] FAIL rotate_hold: got update=%b rotate=%b required 0/1", update, rotate); end
      nextUpdate(n);
      checks++;
      if (rotate !== 1'b1) begin errors++; $display("[TB] FAIL rotate_next_update: got %b required 1", rotate); end
      @(posedge clock);
      #1;
      checks++;
      if (rotate !== 1'b0) begin errors++; $display("[TB] FAIL rotate_clear: got %b required 0", rotate); end
   endtask

   task automatic test_pellet;
      int n;
      nextUpdate(n);
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (mode !== 4'b0010 || rotate !== 1'b1) begin errors++; $display("[TB] FAIL pellet_fright: got mode=%b rotate=%b required 0010/1", mode, rotate); end
      for (int i = 0; i < 3; i++) begin
         nextUpdate(n);
         checks++;
         if (mode !== 4'b0010) begin errors++; $display("[TB] FAIL fright_hold: got %b required 0010", mode); end
      end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || rotate !== 1'b0 || phase !== 3'd1) begin errors++; $display("[TB] FAIL fright_expire: got mode=%b rotate=%b phase=%0d required 1000/0/1", mode, rotate, phase); end
      nextUpdate(n);
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000) begin errors++; $display("[TB] FAIL chase_remaining: got %b required 1000", mode); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b0100 || phase !== 3'd2) begin errors++; $display("[TB] FAIL phase2_entry: got mode=%b phase=%0d required 0100/2", mode, phase); end
   endtask

   task automatic test_enable;
      int n;
      int cnt;
      @(posedge clock);
      #1;
      enable = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (update) cnt++;
      end
      checks++;
      if (cnt !== 0) begin errors++; $display("[TB] FAIL disabled_updates: got %0d required 0", cnt); end
      enable = 1'b1;
      nextUpdate(n);
      nextUpdate(n);
      checks++;
      if (mode !== 4'b0100 || phase !== 3'd2) begin errors++; $display("[TB] FAIL timer_frozen: got mode=%b phase=%0d required 0100/2", mode, phase); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd3 || rotate !== 1'b1) begin errors++; $display("[TB] FAIL phase3_entry: got mode=%b phase=%0d rotate=%b required 1000/3/1", mode, phase, rotate); end
      enable = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(posedge clock);
         #1;
         if (update) cnt++;
      end
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (mode !== 4'b0010) begin errors++; $display("[TB] FAIL disabled_pellet: got %b required 0010", mode); end
      repeat (11) begin
         @(posedge clock);
         #1;
         if (update) cnt++;
      end
      checks++;
      if (cnt !== 0) begin errors++; $display("[TB] FAIL disabled_updates2: got %0d required 0", cnt); end
      enable = 1'b1;
   endtask

   task automatic test_caught;
      int n;
      nextUpdate(n);
      checks++;
      if (mode !== 4'b0010) begin errors++; $display("[TB] FAIL fright_after_enable: got %b required 0010", mode); end
      @(posedge clock);
      #1;
      checks++;
      if (rotate !== 1'b0) begin errors++; $display("[TB] FAIL rotate_cleared_fright: got %b required 0", rotate); end
      pulse(1'b1, 1'b1, 1'b0);
      checks++;
      if (mode !== 4'b0001 || rotate !== 1'b0) begin errors++; $display("[TB] FAIL caught_priority: got mode=%b rotate=%b required 0001/0", mode, rotate); end
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (mode !== 4'b0001) begin errors++; $display("[TB] FAIL eaten_pellet: got %b required 0001", mode); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b0001 || phase !== 3'd3) begin errors++; $display("[TB] FAIL eaten_tick: got mode=%b phase=%0d required 0001/3", mode, phase); end
      pulse(1'b0, 1'b0, 1'b1);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd3 || rotate !== 1'b0) begin errors++; $display("[TB] FAIL home_return: got mode=%b phase=%0d rotate=%b required 1000/3/0", mode, phase, rotate); end
      pulse(1'b0, 1'b1, 1'b0);
      checks++;
      if (mode !== 4'b1000) begin errors++; $display("[TB] FAIL chase_caught: got %b required 1000", mode); end
   endtask

   task automatic test_pelletExpiry;
      int n;
      nextUpdate(n);
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (mode !== 4'b0010) begin errors++; $display("[TB] FAIL pellet2_fright: got %b required 0010", mode); end
      for (int i = 0; i < 3; i++) nextUpdate(n);
      repeat (3) @(posedge clock);
      #1;
      pellet = 1'b1;
      @(posedge clock);
      #1;
      pellet = 1'b0;
      checks++;
      if (update !== 1'b1 || mode !== 4'b0010) begin errors++; $display("[TB] FAIL pellet_on_expiry: got update=%b mode=%b required 1/0010", update, mode); end
      for (int i = 0; i < 3; i++) nextUpdate(n);
      checks++;
      if (mode !== 4'b0010) begin errors++; $display("[TB] FAIL reload_hold: got %b required 0010", mode); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd3) begin errors++; $display("[TB] FAIL reload_expire: got mode=%b phase=%0d required 1000/3", mode, phase); end
   endtask

   task automatic test_saturate;
      int n;
      int bad;
      for (int i = 0; i < 14; i++) nextUpdate(n);
      checks++;
      if (mode !== 4'b0100 || phase !== 3'd6) begin errors++; $display("[TB] FAIL phase6: got mode=%b phase=%0d required 0100/6", mode, phase); end
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd7) begin errors++; $display("[TB] FAIL phase7: got mode=%b phase=%0d required 1000/7", mode, phase); end
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         nextUpdate(n);
         if (mode !== 4'b1000 || phase !== 3'd7) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("[TB] FAIL phase7_stable: got %0d bad ticks required 0", bad); end
   endtask

   task automatic test_asyncReset;
      int n;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 11; i++) nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd3) begin errors++; $display("[TB] FAIL rerun_phase3: got mode=%b phase=%0d required 1000/3", mode, phase); end
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      checks++;
      if (mode !== 4'b0001) begin errors++; $display("[TB] FAIL rerun_eaten: got %b required 0001", mode); end
      nextUpdate(n);
      checks++;
      if (rotate !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_rotate: got %b required 1", rotate); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (mode !== 4'b0100 || phase !== 3'd0 || update !== 1'b0 || rotate !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got mode=%b phase=%0d update=%b rotate=%b required 0100/0/0/0", mode, phase, update, rotate);
      end
      #1;
      resetn = 1'b1;
      nextUpdate(n);
      checks++;
      if (n !== 4 || mode !== 4'b0100 || phase !== 3'd0) begin errors++; $display("[TB] FAIL restart_tick: got cycles=%0d mode=%b phase=%0d required 4/0100/0", n, mode, phase); end
      nextUpdate(n);
      nextUpdate(n);
      checks++;
      if (mode !== 4'b1000 || phase !== 3'd1) begin errors++; $display("[TB] FAIL restart_phase1: got mode=%b phase=%0d required 1000/1", mode, phase); end
   endtask

   initial begin
      test_reset();
      test_schedule();
      test_pellet();
      test_enable();
      test_caught();
      test_pelletExpiry();
      test_saturate();
      test_asyncReset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
